// File: rtl/sdram_pkg.sv
// Types and widths shared by the SDRAM controller, the video fetcher and the
// arbiter in front of the controller.
package sdram_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam logic [3:0] RUN_SAT = 4'hF;

  typedef enum logic {OWN_V, OWN_C} sdram_owner_e;
  typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_DATA} arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
  } sdram_cmd_t;
endpackage

// File: rtl/sdram_arbiter_if.sv
// Bundle of the video, CPU and SDRAM-controller ports around the arbiter.
// Directions in the signal suffixes are from the arbiter's point of view.
interface sdram_arbiter_if;
  import sdram_pkg::*;

  logic              v_cmd_valid_i;
  logic              v_cmd_ready_o;
  logic [ADDR_W-1:0] v_addr_x16_i;
  logic              v_resp_valid_o;
  logic [DATA_W-1:0] v_rdata_o;
  logic              v_ack_i;

  logic              c_cmd_valid_i;
  logic              c_cmd_ready_o;
  logic [ADDR_W-1:0] c_addr_x16_i;
  logic              c_wr_i;
  logic [DATA_W-1:0] c_wdata_i;
  logic [1:0]        c_be_i;
  logic              c_resp_valid_o;
  logic [DATA_W-1:0] c_rdata_o;
  logic              c_ack_i;

  logic              sdram_cmd_valid_o;
  logic              sdram_cmd_ready_i;
  logic [ADDR_W-1:0] sdram_addr_x16_o;
  logic              sdram_wr_o;
  logic [DATA_W-1:0] sdram_wdata_o;
  logic [1:0]        sdram_be_o;
  logic              sdram_resp_valid_i;
  logic [DATA_W-1:0] sdram_rdata_i;
  logic              sdram_ack_o;

  logic              err_o;

  modport arb (
    input  v_cmd_valid_i, v_addr_x16_i, v_ack_i,
    input  c_cmd_valid_i, c_addr_x16_i, c_wr_i, c_wdata_i, c_be_i, c_ack_i,
    input  sdram_cmd_ready_i, sdram_resp_valid_i, sdram_rdata_i,
    output v_cmd_ready_o, v_resp_valid_o, v_rdata_o,
    output c_cmd_ready_o, c_resp_valid_o, c_rdata_o,
    output sdram_cmd_valid_o, sdram_addr_x16_o, sdram_wr_o, sdram_wdata_o,
    output sdram_be_o, sdram_ack_o, err_o
  );

  modport sys (
    output v_cmd_valid_i, v_addr_x16_i, v_ack_i,
    output c_cmd_valid_i, c_addr_x16_i, c_wr_i, c_wdata_i, c_be_i, c_ack_i,
    output sdram_cmd_ready_i, sdram_resp_valid_i, sdram_rdata_i,
    input  v_cmd_ready_o, v_resp_valid_o, v_rdata_o,
    input  c_cmd_ready_o, c_resp_valid_o, c_rdata_o,
    input  sdram_cmd_valid_o, sdram_addr_x16_o, sdram_wr_o, sdram_wdata_o,
    input  sdram_be_o, sdram_ack_o, err_o
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Video/CPU arbiter for the single SDRAM controller port: video has fixed
// priority, capped by MAX_V_RUN consecutive grants while the CPU waits.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int MAX_V_RUN = 4
) (
  input logic          clk_i,
  input logic          rst_ni,
  sdram_arbiter_if.arb bus
);
  localparam logic [3:0] MAX_RUN = 4'(MAX_V_RUN);

  arb_state_e   state_q, state_d;
  sdram_owner_e owner_q, owner_d;
  logic [3:0]   run_cnt_q, run_cnt_d;
  logic         err_q, err_d;

  logic       own_valid, own_ack, oth_ack;
  sdram_cmd_t cmd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_V;
      run_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      run_cnt_q <= run_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    own_valid = (owner_q == OWN_C) ? bus.c_cmd_valid_i : bus.v_cmd_valid_i;
    own_ack   = (owner_q == OWN_C) ? bus.c_ack_i : bus.v_ack_i;
    oth_ack   = (owner_q == OWN_C) ? bus.v_ack_i : bus.c_ack_i;
    if (owner_q == OWN_C) begin
      cmd.addr  = bus.c_addr_x16_i;
      cmd.wr    = bus.c_wr_i;
      cmd.wdata = bus.c_wdata_i;
      cmd.be    = bus.c_be_i;
    end else begin
      cmd.addr  = bus.v_addr_x16_i;
      cmd.wr    = 1'b0;
      cmd.wdata = '0;
      cmd.be    = 2'b11;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    run_cnt_d = run_cnt_q;
    err_d     = err_q;

    bus.v_cmd_ready_o     = 1'b0;
    bus.v_resp_valid_o    = 1'b0;
    bus.v_rdata_o         = '0;
    bus.c_cmd_ready_o     = 1'b0;
    bus.c_resp_valid_o    = 1'b0;
    bus.c_rdata_o         = '0;
    bus.sdram_cmd_valid_o = 1'b0;
    bus.sdram_addr_x16_o  = '0;
    bus.sdram_wr_o        = 1'b0;
    bus.sdram_wdata_o     = '0;
    bus.sdram_be_o        = '0;
    bus.sdram_ack_o       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.v_cmd_valid_i || bus.c_cmd_valid_i) begin
          state_d = ST_CMD;
          if (bus.c_cmd_valid_i && (!bus.v_cmd_valid_i || run_cnt_q >= MAX_RUN)) begin
            owner_d   = OWN_C;
            run_cnt_d = '0;
          end else begin
            owner_d = OWN_V;
            // Count only V grants that made a waiting CPU wait longer.
            if (!bus.c_cmd_valid_i)      run_cnt_d = '0;
            else if (run_cnt_q != RUN_SAT) run_cnt_d = run_cnt_q + 4'd1;
          end
        end
      end
      ST_CMD: begin
        bus.sdram_cmd_valid_o = own_valid;
        bus.sdram_addr_x16_o  = cmd.addr;
        bus.sdram_wr_o        = cmd.wr;
        bus.sdram_wdata_o     = cmd.wdata;
        bus.sdram_be_o        = cmd.be;
        if (owner_q == OWN_C) bus.c_cmd_ready_o = bus.sdram_cmd_ready_i;
        else                  bus.v_cmd_ready_o = bus.sdram_cmd_ready_i;
        if (!own_valid) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (bus.sdram_cmd_ready_i) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (owner_q == OWN_C) begin
          bus.c_resp_valid_o = bus.sdram_resp_valid_i;
          bus.c_rdata_o      = bus.sdram_rdata_i;
        end else begin
          bus.v_resp_valid_o = bus.sdram_resp_valid_i;
          bus.v_rdata_o      = bus.sdram_rdata_i;
        end
        bus.sdram_ack_o = own_ack;
        if (own_ack) state_d = ST_IDLE;
        if (oth_ack) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // A beat with no open data phase has nowhere to go; it is dropped.
    if (bus.sdram_resp_valid_i && state_q != ST_DATA) err_d = 1'b1;
  end

  assign bus.err_o = err_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: single-owner bursts, priority, starvation
// cap, CPU write muxing, error flag and reset in the middle of a burst.
module tb_sdram_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  int   nvec = 0;
  int   nerr = 0;

  sdram_arbiter_if bus ();

  sdram_arbiter #(.MAX_V_RUN(4)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  always #5 clk_i = ~clk_i;

  localparam logic [23:0] V_ADDR = 24'hABCDE0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cmdv"}, {31'd0, bus.sdram_cmd_valid_o}, 0);
    chk({tag, "_addr"}, {8'd0, bus.sdram_addr_x16_o}, 0);
    chk({tag, "_wr"},   {31'd0, bus.sdram_wr_o}, 0);
    chk({tag, "_wd"},   {16'd0, bus.sdram_wdata_o}, 0);
    chk({tag, "_be"},   {30'd0, bus.sdram_be_o}, 0);
    chk({tag, "_rdy"},  {30'd0, bus.v_cmd_ready_o, bus.c_cmd_ready_o}, 0);
    chk({tag, "_resp"}, {30'd0, bus.v_resp_valid_o, bus.c_resp_valid_o}, 0);
    chk({tag, "_ack"},  {31'd0, bus.sdram_ack_o}, 0);
  endtask

  // Entered in the IDLE cycle where requests are already driven. Runs
  // CMD (one-cycle handshake) and one DATA beat with ack, returns in IDLE.
  task automatic grant(input string tag, input logic exp_c, input logic keep);
    logic [23:0] ea;
    logic        ew;
    logic [15:0] ed;
    logic [1:0]  eb;
    ea = exp_c ? bus.c_addr_x16_i : V_ADDR;
    ew = exp_c ? bus.c_wr_i : 1'b0;
    ed = exp_c ? bus.c_wdata_i : 16'h0;
    eb = exp_c ? bus.c_be_i : 2'b11;
    cyc();
    bus.sdram_cmd_ready_i = 1'b1;
    #1;
    chk({tag, "_cmdv"}, {31'd0, bus.sdram_cmd_valid_o}, 1);
    chk({tag, "_rdy"},  {30'd0, bus.v_cmd_ready_o, bus.c_cmd_ready_o}, exp_c ? 1 : 2);
    chk({tag, "_addr"}, {8'd0, bus.sdram_addr_x16_o}, {8'd0, ea});
    chk({tag, "_wrbe"}, {29'd0, bus.sdram_wr_o, bus.sdram_be_o}, {29'd0, ew, eb});
    chk({tag, "_wd"},   {16'd0, bus.sdram_wdata_o}, {16'd0, ed});
    cyc();
    bus.sdram_cmd_ready_i = 1'b0;
    if (exp_c) bus.c_cmd_valid_i = keep;
    else       bus.v_cmd_valid_i = keep;
    bus.sdram_resp_valid_i = 1'b1;
    bus.sdram_rdata_i      = 16'h5A00 | 16'(exp_c);
    bus.c_ack_i = exp_c;
    bus.v_ack_i = !exp_c;
    #1;
    chk({tag, "_resp"}, {30'd0, bus.v_resp_valid_o, bus.c_resp_valid_o}, exp_c ? 1 : 2);
    chk({tag, "_rdat"}, {16'd0, exp_c ? bus.c_rdata_o : bus.v_rdata_o}, {16'd0, 16'h5A00 | 16'(exp_c)});
    chk({tag, "_sack"}, {31'd0, bus.sdram_ack_o}, 1);
    cyc();
    bus.sdram_resp_valid_i = 1'b0;
    bus.c_ack_i = 1'b0;
    bus.v_ack_i = 1'b0;
    #1;
    chk({tag, "_idle"}, {31'd0, bus.sdram_cmd_valid_o}, 0);
  endtask

  initial begin
    int vcnt, ccnt;
    bus.v_cmd_valid_i = 0; bus.v_addr_x16_i = V_ADDR; bus.v_ack_i = 0;
    bus.c_cmd_valid_i = 0; bus.c_addr_x16_i = 24'h000100; bus.c_wr_i = 0;
    bus.c_wdata_i = 0; bus.c_be_i = 2'b11; bus.c_ack_i = 0;
    bus.sdram_cmd_ready_i = 0; bus.sdram_resp_valid_i = 0; bus.sdram_rdata_i = 0;

    #1 rst_ni = 1'b0;
    #2;
    chk_quiet("rst");
    chk("rst_err", {31'd0, bus.err_o}, 0);
    cyc(); cyc();
    rst_ni = 1'b1;

    // V alone: 64-beat burst.
    cyc();
    bus.v_cmd_valid_i = 1'b1;
    #1;
    chk("v_arb_cyc", {31'd0, bus.sdram_cmd_valid_o}, 0);
    cyc();
    bus.sdram_cmd_ready_i = 1'b1;
    #1;
    chk("v_cmdv", {31'd0, bus.sdram_cmd_valid_o}, 1);
    chk("v_addr", {8'd0, bus.sdram_addr_x16_o}, {8'd0, V_ADDR});
    chk("v_wrbe", {29'd0, bus.sdram_wr_o, bus.sdram_be_o}, 3);
    chk("v_rdy",  {30'd0, bus.v_cmd_ready_o, bus.c_cmd_ready_o}, 2);
    vcnt = 0; ccnt = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      bus.sdram_cmd_ready_i = 1'b0;
      bus.v_cmd_valid_i = 1'b0;
      bus.sdram_resp_valid_i = 1'b1;
      bus.sdram_rdata_i = 16'(i) + 16'h1000;
      bus.v_ack_i = (i == 63);
      #1;
      if (bus.v_resp_valid_o && bus.v_rdata_o == 16'(i) + 16'h1000) vcnt++;
      if (bus.c_resp_valid_o) ccnt++;
      if (bus.sdram_cmd_valid_o) ccnt++;
    end
    chk("v_last_ack", {31'd0, bus.sdram_ack_o}, 1);
    chk("v_beats", vcnt, 64);
    chk("v_quiet_other", ccnt, 0);
    cyc();
    bus.sdram_resp_valid_i = 1'b0;
    bus.v_ack_i = 1'b0;
    #1;
    chk_quiet("v_done");
    chk("v_err", {31'd0, bus.err_o}, 0);

    // Simultaneous request: V first, C two cycles after V's ack.
    bus.v_cmd_valid_i = 1'b1;
    bus.c_cmd_valid_i = 1'b1;
    grant("sim_v", 1'b0, 1'b0);
    grant("sim_c", 1'b1, 1'b0);

    // Starvation cap: V V V V C V with both held valid.
    bus.v_cmd_valid_i = 1'b1;
    bus.c_cmd_valid_i = 1'b1;
    grant("st_v1", 1'b0, 1'b1);
    grant("st_v2", 1'b0, 1'b1);
    grant("st_v3", 1'b0, 1'b1);
    grant("st_v4", 1'b0, 1'b1);
    grant("st_c",  1'b1, 1'b0);
    grant("st_v5", 1'b0, 1'b0);

    // CPU write muxing.
    bus.c_addr_x16_i = 24'h123456;
    bus.c_wdata_i    = 16'hBEEF;
    bus.c_be_i       = 2'b01;
    bus.c_wr_i       = 1'b1;
    bus.c_cmd_valid_i = 1'b1;
    grant("cwr", 1'b1, 1'b0);
    bus.c_wr_i = 1'b0;
    chk("cwr_err", {31'd0, bus.err_o}, 0);

    // Stray beat in IDLE: dropped, err sticks.
    bus.sdram_resp_valid_i = 1'b1;
    bus.sdram_rdata_i = 16'hDEAD;
    #1;
    chk("ei_resp", {30'd0, bus.v_resp_valid_o, bus.c_resp_valid_o}, 0);
    cyc();
    bus.sdram_resp_valid_i = 1'b0;
    #1;
    chk("ei_err", {31'd0, bus.err_o}, 1);
    cyc(); cyc();
    chk("ei_sticky", {31'd0, bus.err_o}, 1);
    rst_ni = 1'b0;
    #1;
    chk("ei_clr", {31'd0, bus.err_o}, 0);
    cyc();
    rst_ni = 1'b1;

    // Foreign ack while V owns: err set, V cycle finishes.
    cyc();
    bus.v_cmd_valid_i = 1'b1;
    cyc();
    bus.sdram_cmd_ready_i = 1'b1;
    cyc();
    bus.sdram_cmd_ready_i = 1'b0;
    bus.v_cmd_valid_i = 1'b0;
    bus.sdram_resp_valid_i = 1'b1;
    bus.sdram_rdata_i = 16'h0001;
    bus.c_ack_i = 1'b1;
    #1;
    chk("ea_vresp", {30'd0, bus.v_resp_valid_o, bus.c_resp_valid_o}, 2);
    chk("ea_noack", {31'd0, bus.sdram_ack_o}, 0);
    cyc();
    bus.c_ack_i = 1'b0;
    bus.v_ack_i = 1'b1;
    #1;
    chk("ea_err", {31'd0, bus.err_o}, 1);
    chk("ea_vresp2", {30'd0, bus.v_resp_valid_o, bus.c_resp_valid_o}, 2);
    chk("ea_ack", {31'd0, bus.sdram_ack_o}, 1);
    cyc();
    bus.v_ack_i = 1'b0;
    bus.sdram_resp_valid_i = 1'b0;
    bus.v_cmd_valid_i = 1'b1;
    grant("ea_next", 1'b0, 1'b0);

    // Reset at beat 30 of a V burst.
    bus.v_cmd_valid_i = 1'b1;
    cyc();
    bus.sdram_cmd_ready_i = 1'b1;
    cyc();
    bus.sdram_cmd_ready_i = 1'b0;
    bus.v_cmd_valid_i = 1'b0;
    bus.sdram_resp_valid_i = 1'b1;
    for (int i = 1; i < 30; i++) cyc();
    #1;
    chk("rb_beat29", {31'd0, bus.v_resp_valid_o}, 1);
    cyc();
    rst_ni = 1'b0;
    #1;
    chk_quiet("rb");
    chk("rb_err", {31'd0, bus.err_o}, 0);
    bus.sdram_resp_valid_i = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc();
    bus.v_cmd_valid_i = 1'b1;
    grant("rb_next", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
